// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Arbitrates two requesters onto one shared combinational ALU. The winning
// request's operands and opcode are registered onto alu_in1/alu_in2/alu_op.
// One cycle later the ALU result is captured into a response register. That
// response is held until the consumer takes it.
//
// Arbitration when both requesters are valid:
//   RR_EN = 1 : round-robin (the requester that did not win last time).
//   RR_EN = 0 : fixed priority, requester 0 always wins.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   reqN_valid / reqN_ready   per-requester handshake (ready is combinational)
//   reqN_a, reqN_b, reqN_op   per-requester operands and opcode
//   alu_in1, alu_in2, alu_op  registered operands/opcode to the external ALU
//   alu_out                   combinational result from the external ALU
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that owns the response
//   rsp_data, rsp_err         result and divide-by-zero flag
//   busy                      high whenever an operation is in flight
//   op_count                  saturating count of completed responses
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_op,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [3:0]  alu_op,
    input  logic [7:0]  alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        last_grant_reg;
    logic [7:0]  alu_in1_reg;
    logic [7:0]  alu_in2_reg;
    logic [3:0]  alu_op_reg;
    logic        rsp_valid_reg;
    logic        rsp_id_reg;
    logic [7:0]  rsp_data_reg;
    logic        rsp_err_reg;
    logic [15:0] op_count_reg;

    // Requester inputs gathered into arrays so the grant can index them.
    logic [1:0]  req_valid;
    logic [7:0]  req_a  [2];
    logic [7:0]  req_b  [2];
    logic [3:0]  req_op [2];
    logic [1:0]  req_ready;

    logic        grant_valid;
    logic        grant_id;
    logic        div_by_zero;

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // Winner selection. With a single valid requester it simply wins; on a
    // tie the policy depends on RR_EN. last_grant resets to 1 so that
    // requester 0 takes the first tie after reset.
    always_comb begin
        grant_valid = |req_valid;
        grant_id    = 1'b0;
        if (&req_valid) begin
            grant_id = RR_EN ? ~last_grant_reg : 1'b0;
        end else begin
            grant_id = req_valid[1];
        end
    end

    // Ready only in IDLE and only for the single winner. The rst term keeps
    // both readies low while reset is held, even though the state register
    // already reads IDLE then.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && !rst && grant_valid
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    assign div_by_zero = (alu_op_reg == OP_DIV) && (alu_in2_reg == 8'h00);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The RESP -> IDLE transition never accepts a new
    // request on the same edge, which gives the three-cycle minimum spacing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            alu_in1_reg    <= 8'h00;
            alu_in2_reg    <= 8'h00;
            alu_op_reg     <= 4'h0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= 8'h00;
            rsp_err_reg    <= 1'b0;
            op_count_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        alu_in1_reg    <= req_a[grant_id];
                        alu_in2_reg    <= req_b[grant_id];
                        alu_op_reg     <= req_op[grant_id];
                        rsp_id_reg     <= grant_id;
                        last_grant_reg <= grant_id;
                    end
                end
                EXEC: begin
                    // A zero divisor yields a flagged zero result; whatever
                    // the external ALU produces in that case is discarded.
                    if (div_by_zero) begin
                        rsp_data_reg <= 8'h00;
                        rsp_err_reg  <= 1'b1;
                    end else begin
                        rsp_data_reg <= alu_out;
                        rsp_err_reg  <= 1'b0;
                    end
                    rsp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (op_count_reg != 16'hFFFF) begin
                            op_count_reg <= op_count_reg + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_in1   = alu_in1_reg;
    assign alu_in2   = alu_in2_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign op_count  = op_count_reg;
    assign busy      = (state_reg != IDLE);

endmodule
